fib_gals_sender: RTL and testbench

Producer-domain sender stage of the GALS producer/consumer link, clocked by `clock_1`, directly downstream of the `fibonacci` generator. It throttles the generator through `f_en` and buffers its words in a small FIFO. It discards the one replayed word the generator emits after every pause. It hands each word across the clock boundary with a 4-phase `req`/`ack` handshake, synchronising `ack_in` internally.

---
 rtl/fib_gals_sender_if.sv | 28 ++
 rtl/fib_gals_sender.sv | 66 ++++++
 tb/tb_fib_gals_sender.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fib_gals_sender_if.sv
// fib_gals_sender_if: generator-side and consumer-side signals of the producer sender stage
// Signals:
//   f_valid, f_out  generator word valid / word             (into sender)
//   f_en            generator enable                        (out of sender)
//   req, data_out   4-phase request and offered word        (out of sender)
//   ack_in          consumer acknowledge, asynchronous      (into sender)
//   fifo_count      current FIFO occupancy                  (out of sender)
// Modports: master = the sender, slave = generator/consumer side.
interface fib_gals_sender_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    logic                     f_valid;
    logic [WIDTH-1:0]         f_out;
    logic                     f_en;
    logic                     req;
    logic                     ack_in;
    logic [WIDTH-1:0]         data_out;
    logic [$clog2(DEPTH):0]   fifo_count;
    modport master (
        input  f_valid, f_out, ack_in,
        output f_en, req, data_out, fifo_count
    );
    modport slave (
        output f_valid, f_out, ack_in,
        input  f_en, req, data_out, fifo_count
    );
endinterface

// File: rtl/fib_gals_sender.sv
// fib_gals_sender: producer-domain FIFO and 4-phase req/ack sender behind the fibonacci generator
// Ports:
//   clock_1  producer clock, rising edge
//   reset    asynchronous, active-high
//   bus      fib_gals_sender_if.master: f_valid/f_out in, f_en out, req/data_out out,
//            ack_in in (asynchronous), fifo_count out
module fib_gals_sender #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input logic clock_1,
    input logic reset,
    fib_gals_sender_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    // one word can still be in flight from the generator, so stop two short of full
    localparam logic [AW:0] EN_MAX = (AW+1)'(DEPTH - 2);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, REL = 2'd2;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [1:0] state;
    logic [WIDTH-1:0] data_out;
    logic req, drop_next, ack_m, ack_s, push, pop;
    assign push = bus.f_valid && !drop_next;
    // REL launches the next word directly once ack has returned low, saving an IDLE cycle
    assign pop = (state == IDLE || state == REL) && !ack_s && count != '0;
    assign bus.f_en = count <= EN_MAX;
    assign bus.req = req;
    assign bus.data_out = data_out;
    assign bus.fifo_count = count;
    always_ff @(posedge clock_1) begin
        if (push) mem[wr_ptr] <= bus.f_out;
    end
    always_ff @(posedge clock_1 or posedge reset) begin
        if (reset) begin
            ack_m     <= 1'b0;
            ack_s     <= 1'b0;
            drop_next <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            state     <= IDLE;
            req       <= 1'b0;
            data_out  <= '0;
        end else begin
            ack_m  <= bus.ack_in;
            ack_s  <= ack_m;
            // tracks the generator's pause flag: its first word after a pause is a replay
            drop_next <= !bus.f_en || (drop_next && !bus.f_valid);
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (pop) begin
                data_out <= mem[rd_ptr];
                req      <= 1'b1;
                state    <= REQ;
            end else if (state == REQ && ack_s) begin
                req   <= 1'b0;
                state <= REL;
            end else if (state != REQ && !ack_s) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_fib_gals_sender.sv
// tb_fib_gals_sender: directed bench for fib_gals_sender with a generator model and a 4-phase consumer
module tb_fib_gals_sender;
    logic clock_1 = 1'b0;
    logic reset = 1'b1;
    logic gen_on = 1'b0;
    logic auto_ack = 1'b0;
    logic ack_man = 1'b0;
    logic ack_auto = 1'b0;
    int   ack_delay = 2;
    int   dly = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   drops = 0;
    logic [15:0] rx[$];
    logic [15:0] ga, gb, gout;
    logic gv, gpause;
    logic p_fv, p_req, pop_seen;
    logic [2:0] p_cnt;
    int fib[14] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};

    fib_gals_sender_if #(.WIDTH(16), .DEPTH(4)) bus ();
    fib_gals_sender #(.WIDTH(16), .DEPTH(4)) dut (
        .clock_1(clock_1),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clock_1 = ~clock_1;

    assign bus.f_valid = gv;
    assign bus.f_out   = gout;
    assign bus.ack_in  = auto_ack ? ack_auto : ack_man;

    // generator: one word per enabled edge; after a pause it re-emits its last word once
    always @(posedge clock_1 or posedge reset) begin
        if (reset) begin
            ga <= 16'd0; gb <= 16'd1; gout <= 16'd0; gv <= 1'b0; gpause <= 1'b0;
        end else if (gen_on) begin
            if (!bus.f_en) begin
                gv <= 1'b0; gpause <= 1'b1;
            end else if (gpause) begin
                gv <= 1'b1; gpause <= 1'b0;
            end else begin
                gv <= 1'b1; gout <= ga; ga <= gb; gb <= ga + gb;
            end
        end
    end

    // consumer: follows req with ack after ack_delay negedges
    always @(negedge clock_1) begin
        if (reset || !auto_ack) begin
            ack_auto = 1'b0; dly = 0;
        end else if (bus.req != ack_auto) begin
            if (dly >= ack_delay) begin ack_auto = bus.req; dly = 0; end
            else dly++;
        end else dly = 0;
    end

    // observer: logs each offered word and counts valid words that did not enter the FIFO
    always @(negedge clock_1) begin
        if (reset) begin
            p_fv = 1'b0; p_req = 1'b0; p_cnt = 3'd0; drops = 0; rx.delete();
        end else begin
            pop_seen = bus.req && !p_req;
            if (pop_seen) rx.push_back(bus.data_out);
            if (p_fv && int'(bus.fifo_count) - int'(p_cnt) + int'(pop_seen) == 0) drops++;
            p_fv = bus.f_valid; p_cnt = bus.fifo_count; p_req = bus.req;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clock_1) reset = 1'b1;
        repeat (2) @(negedge clock_1);
        reset = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        for (int i = 0; i < budget && rx.size() < n; i++) @(posedge clock_1);
        check("rx_count", 32'(rx.size() >= n ? n : rx.size()), 32'(n));
    endtask

    task automatic check_seq(input string name, input int n);
        for (int i = 0; i < n; i++)
            check($sformatf("%s_%0d", name, i), i < rx.size() ? 32'(rx[i]) : 32'hdead_beef, 32'(fib[i]));
    endtask

    initial begin
        int exp_cnt[6] = '{0, 1, 1, 2, 3, 4};
        int exp_en[6]  = '{1, 1, 1, 1, 0, 0};
        repeat (3) @(negedge clock_1);
        check("rst_req", 32'(bus.req), 0);
        check("rst_data", 32'(bus.data_out), 0);
        check("rst_count", 32'(bus.fifo_count), 0);
        check("rst_f_en", 32'(bus.f_en), 1);

        reset = 1'b0;
        repeat (30) @(posedge clock_1);
        #1;
        check("empty_req", 32'(bus.req), 0);
        check("empty_count", 32'(bus.fifo_count), 0);
        check("empty_state", 32'(dut.state), 0);

        gen_on = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(posedge clock_1);
            #1;
            check($sformatf("bp_count_%0d", i + 1), 32'(bus.fifo_count), 32'(exp_cnt[i]));
            check($sformatf("bp_f_en_%0d", i + 1), 32'(bus.f_en), 32'(exp_en[i]));
        end
        check("bp_req", 32'(bus.req), 1);
        check("bp_data", 32'(bus.data_out), 0);
        repeat (34) @(posedge clock_1);
        #1;
        check("bp_peak", 32'(bus.fifo_count), 4);
        check("bp_f_en_held", 32'(bus.f_en), 0);
        ack_delay = 2;
        auto_ack = 1'b1;
        wait_rx(8, 600);
        check_seq("bp_seq", 8);

        do_reset();
        wait_rx(10, 800);
        check_seq("free_seq", 10);

        ack_delay = 5;
        do_reset();
        wait_rx(12, 1200);
        check("pause_drops", 32'(drops), 5);
        wait_rx(14, 600);
        check_seq("pause_seq", 14);

        auto_ack = 1'b0;
        ack_man = 1'b0;
        do_reset();
        repeat (3) @(posedge clock_1);
        #1;
        check("lat_req_up", 32'(bus.req), 1);
        #2 ack_man = 1'b1;
        @(posedge clock_1); #1;
        check("lat_req_e1", 32'(bus.req), 1);
        @(posedge clock_1); #1;
        check("lat_req_e2", 32'(bus.req), 1);
        @(posedge clock_1); #1;
        check("lat_req_e3", 32'(bus.req), 0);
        check("lat_data_rel", 32'(bus.data_out), 0);
        #2 ack_man = 1'b0;
        @(posedge clock_1); #1;
        check("lat_data_f1", 32'(bus.data_out), 0);
        @(posedge clock_1); #1;
        check("lat_data_f2", 32'(bus.data_out), 0);
        check("lat_req_f2", 32'(bus.req), 0);
        @(posedge clock_1); #1;
        check("lat_req_f3", 32'(bus.req), 1);
        check("lat_data_f3", 32'(bus.data_out), 1);

        ack_man = 1'b1;
        do_reset();
        repeat (8) @(posedge clock_1);
        #1;
        check("stuck_req", 32'(bus.req), 0);
        check("stuck_count", 32'(bus.fifo_count), 4);
        #2 ack_man = 1'b0;
        repeat (2) @(posedge clock_1);
        #1;
        check("stuck_req_e2", 32'(bus.req), 0);
        @(posedge clock_1); #1;
        check("stuck_req_e3", 32'(bus.req), 1);
        check("stuck_data", 32'(bus.data_out), 0);

        ack_man = 1'b0;
        ack_delay = 2;
        auto_ack = 1'b1;
        do_reset();
        for (int i = 0; i < 400 && !(bus.req && bus.data_out == 16'd8); i++) @(negedge clock_1);
        check("mid_reach_8", 32'(bus.req && bus.data_out == 16'd8), 1);
        #2 reset = 1'b1;
        #1;
        check("mid_req", 32'(bus.req), 0);
        check("mid_count", 32'(bus.fifo_count), 0);
        check("mid_data", 32'(bus.data_out), 0);
        repeat (2) @(negedge clock_1);
        reset = 1'b0;
        wait_rx(3, 300);
        check_seq("mid_seq", 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
